uart_wb_master: RTL and testbench
=================================

Name: uart_wb_master

Overview:
- Wishbone classic initiator that drives the 16550-compatible uart_top register slave (8-bit data bus, 3-bit address).
- After reset it programs the baud divisor, line control and FIFO control, then loops forever:
  - poll LSR;
  - read each received byte from RBR;
  - optionally echo it back through THR once LSR reports the transmitter empty.
- It sits beside uart_top in the top-level wrapper and occupies the Wishbone port that is otherwise left unconnected.

Parameters:
- DIVISOR, 16'd27: baud divisor written to DLL/DLM (clk/(16*baud)).
- LCR_VAL, 8'h03: final LCR value (8N1); bit7 is forced to 0 when written.
- FCR_VAL, 8'hC7: FCR value (FIFOs enabled and cleared, 14-byte trigger).
- ACK_TIMEOUT, 8'd255: cycles to wait for wb_ack_i before the block faults.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset
- wb_adr_o  out  3  register address
- wb_dat_o  out  8  write data to slave
- wb_dat_i  in  8  read data from slave
- wb_we_o  out  1  write enable
- wb_stb_o  out  1  strobe
- wb_cyc_o  out  1  cycle
- wb_sel_o  out  4  byte select, constant 4'b0001
- wb_ack_i  in  1  slave acknowledge
- echo_en_i  in  1  1 = write each received byte back to THR
- init_done_o  out  1  high once the configuration sequence has completed
- rx_byte_o  out  8  last byte read from RBR
- rx_valid_o  out  1  one-cycle pulse when rx_byte_o updates
- err_o  out  1  sticky ack-timeout fault

Behaviour:
- Clock and reset: single clock wb_clk_i; wb_rst_i is synchronous, active-high.
- Reset values: all outputs 0 except wb_sel_o = 4'b0001. The state machine returns to INIT step 0 and the timeout counter clears.
- Reset asserted mid-transaction: cyc/stb drop on the next edge; no completion is recorded.
- Bus cycle, classic single transfer:
  - adr/dat/we/cyc/stb are asserted together and held stable until the cycle in which wb_ack_i=1 is sampled.
  - cyc/stb deassert on the following edge.
  - At least one idle cycle separates transfers.
  - Read data is captured on the ack cycle.
  - Minimum transfer: 1 cycle asserted + 1 idle.
- Timeout:
  - An 8-bit counter runs while stb=1 and no ack is seen.
  - When it reaches ACK_TIMEOUT: drop cyc/stb, set err_o, enter ERROR.
  - ERROR is absorbing until reset; no further bus activity.
  - An ack arriving on exactly the timeout cycle counts as success.
- INIT sequence, all writes, in order:
  1. adr 3 = 8'h80 | LCR_VAL
  2. adr 0 = DIVISOR[7:0]
  3. adr 1 = DIVISOR[15:8]
  4. adr 3 = LCR_VAL & 8'h7F
  5. adr 2 = FCR_VAL
  6. adr 1 = 8'h00 (IER, interrupts off)
- init_done_o rises on the edge after the final ack and stays high until reset.
- Main loop:
  - POLL_RX: read adr 5 (LSR). If bit0 is 0, go to idle, then POLL_RX again. If bit0 is 1, go to READ_RBR.
  - READ_RBR: read adr 0 (with DLAB=0 this is RBR).
    - rx_byte_o is loaded on the ack edge; rx_valid_o is high for exactly the following cycle.
    - If echo_en_i is sampled 1 at that edge, go to POLL_TX; otherwise go to POLL_RX.
  - POLL_TX: read adr 5. Repeat while bit5 is 0; when bit5 is 1, go to WRITE_THR.
  - WRITE_THR: write adr 0 with rx_byte_o, then go to POLL_RX.
- Changing echo_en_i mid-echo does not abort an echo already committed.
- The block issues no interrupt-driven accesses and ignores wb_dat_i on write cycles.
- Expected size: roughly 200 lines of RTL (FSM, 3-bit step counter, timeout counter, data register).

Test Plan:
1. Reset, then a slave model acking 1 cycle after stb. Required write sequence (adr,dat): (3,83),(0,1B),(1,00),(3,03),(2,C7),(1,00). init_done_o rises the cycle after the 6th ack; no back-to-back stb.
2. Slave returns LSR=8'h60 forever. Repeated reads of adr 5 only, separated by idle cycles; rx_valid_o never pulses.
3. Echo path, echo_en_i=1:
   - LSR=8'h61, then RBR=8'h5A. rx_byte_o=8'h5A with a single-cycle rx_valid_o.
   - Then LSR reads of 8'h01 ×3 followed by 8'h21. A write of adr 0, dat 8'h5A occurs only after the 8'h21 read.
4. echo_en_i=0, LSR=8'h61, RBR=8'hA5. rx_valid_o pulses with 8'hA5; the next transfer is an LSR read; no write to adr 0.
5. Slave withholds ack during init step 2. err_o=1 exactly ACK_TIMEOUT cycles after stb rises; cyc/stb drop; the bus stays idle for 1000 cycles; init_done_o stays 0.
6. Reset pulsed while READ_RBR stb is high. stb/cyc are 0 the next cycle; the sequence restarts with (3,83); rx_valid_o does not pulse.

Source files
------------

// File: rtl/uart_wb_master.sv
// Wishbone classic initiator for a 16550-style UART register slave. It programs the divisor,
// line control and FIFO control, then polls for received bytes and can echo each one back.
module uart_wb_master #(
  parameter logic [15:0] DIVISOR     = 16'd27,
  parameter logic [7:0]  LCR_VAL     = 8'h03,
  parameter logic [7:0]  FCR_VAL     = 8'hC7,
  parameter logic [7:0]  ACK_TIMEOUT = 8'd255
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  output logic       wb_we_o,
  output logic       wb_stb_o,
  output logic       wb_cyc_o,
  output logic [3:0] wb_sel_o,
  input  logic       wb_ack_i,
  input  logic       echo_en_i,
  output logic       init_done_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_valid_o,
  output logic       err_o
);

  typedef enum logic [2:0] {
    StInit, StPollRx, StReadRbr, StPollTx, StWriteThr, StError
  } state_e;

  localparam logic [2:0] AdrRbr   = 3'd0;
  localparam logic [2:0] AdrLsr   = 3'd5;
  localparam logic [2:0] LastStep = 3'd5;

  state_e     state_q;
  logic [2:0] step_q;
  logic [7:0] tmo_q;
  logic       cyc_q;
  logic       we_q;
  logic [2:0] adr_q;
  logic [7:0] dat_q;
  logic [7:0] rx_byte_q;
  logic       rx_valid_q;
  logic       init_done_q;
  logic       err_q;

  logic [2:0] init_adr;
  logic [7:0] init_dat;
  logic [2:0] req_adr;
  logic [7:0] req_dat;
  logic       req_we;

  // Configuration writes: set DLAB, load the divisor, clear DLAB, FIFOs on, interrupts off.
  always_comb begin
    init_adr = 3'd1;
    init_dat = 8'h00;
    unique case (step_q)
      3'd0: begin init_adr = 3'd3; init_dat = 8'h80 | LCR_VAL;      end
      3'd1: begin init_adr = 3'd0; init_dat = DIVISOR[7:0];        end
      3'd2: begin init_adr = 3'd1; init_dat = DIVISOR[15:8];       end
      3'd3: begin init_adr = 3'd3; init_dat = LCR_VAL & 8'h7F;     end
      3'd4: begin init_adr = 3'd2; init_dat = FCR_VAL;             end
      default: begin init_adr = 3'd1; init_dat = 8'h00;            end
    endcase
  end

  // Transfer the current state would launch from an idle bus.
  always_comb begin
    req_adr = AdrLsr;
    req_dat = 8'h00;
    req_we  = 1'b0;
    unique case (state_q)
      StInit:     begin req_adr = init_adr; req_dat = init_dat; req_we = 1'b1; end
      StReadRbr:  begin req_adr = AdrRbr; end
      StWriteThr: begin req_adr = AdrRbr; req_dat = rx_byte_q; req_we = 1'b1; end
      default:    ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= StInit;
      step_q      <= 3'd0;
      tmo_q       <= 8'd0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= 3'd0;
      dat_q       <= 8'h00;
      rx_byte_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (cyc_q) begin
        if (wb_ack_i) begin
          // An ack on the timeout cycle still wins over the fault.
          cyc_q <= 1'b0;
          we_q  <= 1'b0;
          tmo_q <= 8'd0;
          unique case (state_q)
            StInit: begin
              if (step_q == LastStep) begin
                state_q     <= StPollRx;
                init_done_q <= 1'b1;
              end else begin
                step_q <= step_q + 3'd1;
              end
            end
            StPollRx: if (wb_dat_i[0]) state_q <= StReadRbr;
            StReadRbr: begin
              rx_byte_q  <= wb_dat_i;
              rx_valid_q <= 1'b1;
              state_q    <= echo_en_i ? StPollTx : StPollRx;
            end
            StPollTx:   if (wb_dat_i[5]) state_q <= StWriteThr;
            StWriteThr: state_q <= StPollRx;
            default:    ;
          endcase
        end else if (tmo_q == (ACK_TIMEOUT - 8'd1)) begin
          cyc_q   <= 1'b0;
          we_q    <= 1'b0;
          tmo_q   <= 8'd0;
          err_q   <= 1'b1;
          state_q <= StError;
        end else begin
          tmo_q <= tmo_q + 8'd1;
        end
      end else if (state_q != StError) begin
        cyc_q <= 1'b1;
        adr_q <= req_adr;
        dat_q <= req_dat;
        we_q  <= req_we;
      end
    end
  end

  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_we_o     = we_q;
  assign wb_stb_o    = cyc_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_sel_o    = 4'b0001;
  assign init_done_o = init_done_q;
  assign rx_byte_o   = rx_byte_q;
  assign rx_valid_o  = rx_valid_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_uart_wb_master.sv
// Directed bench for uart_wb_master: a scripted UART register slave answers on the bus and a
// negedge monitor logs every transfer and protocol violation for later comparison.
module tb_uart_wb_master;

  logic       wb_clk_i;
  logic       wb_rst_i;
  logic [2:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_we_o;
  logic       wb_stb_o;
  logic       wb_cyc_o;
  logic [3:0] wb_sel_o;
  logic       wb_ack_i;
  logic       echo_en_i;
  logic       init_done_o;
  logic [7:0] rx_byte_o;
  logic       rx_valid_o;
  logic       err_o;

  uart_wb_master dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .wb_adr_o    (wb_adr_o),
    .wb_dat_o    (wb_dat_o),
    .wb_dat_i    (wb_dat_i),
    .wb_we_o     (wb_we_o),
    .wb_stb_o    (wb_stb_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_sel_o    (wb_sel_o),
    .wb_ack_i    (wb_ack_i),
    .echo_en_i   (echo_en_i),
    .init_done_o (init_done_o),
    .rx_byte_o   (rx_byte_o),
    .rx_valid_o  (rx_valid_o),
    .err_o       (err_o)
  );

  initial begin
    wb_clk_i = 1'b0;
    forever #5 wb_clk_i = ~wb_clk_i;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave script and monitor state.
  logic [7:0]  lsr_q[$];
  logic [7:0]  lsr_dflt = 8'h60;
  logic [7:0]  rbr_val  = 8'h00;
  bit          hold_rbr = 1'b0;
  int          hold_idx = -1;
  logic [11:0] log_x[$];
  int          log_c[$];
  int          rise_c[$];
  logic [7:0]  rx_log[$];
  int          cyc_cnt = 0;
  int          busy_cnt = 0;
  int          proto_err = 0;
  int          xfer_cnt = 0;
  int          cur_xfer = 0;
  int          init_cyc = -1;
  int          err_cyc = -1;
  bit          ack_prev = 1'b0;
  bit          stb_prev = 1'b0;
  bit          rxv_prev = 1'b0;
  bit          init_prev = 1'b0;
  bit          err_prev = 1'b0;
  logic [11:0] req_prev = 12'h000;
  logic [7:0]  rdat;

  initial begin
    wb_ack_i = 1'b0;
    wb_dat_i = 8'h00;
    forever begin
      @(negedge wb_clk_i);
      cyc_cnt++;
      if (wb_cyc_o || wb_stb_o) busy_cnt++;
      if (wb_cyc_o != wb_stb_o) proto_err++;
      if (ack_prev && wb_stb_o) proto_err++;
      if (stb_prev && !ack_prev && wb_stb_o && ({wb_we_o, wb_adr_o, wb_dat_o} != req_prev))
        proto_err++;
      if (wb_stb_o && !stb_prev) begin
        cur_xfer = xfer_cnt;
        xfer_cnt++;
        rise_c.push_back(cyc_cnt);
      end
      wb_ack_i = 1'b0;
      if (wb_stb_o && !ack_prev && (cur_xfer != hold_idx) &&
          !(hold_rbr && !wb_we_o && wb_adr_o == 3'd0)) begin
        if (wb_we_o) rdat = wb_dat_o;
        else if (wb_adr_o == 3'd5) begin
          if (lsr_q.size() > 0) rdat = lsr_q.pop_front();
          else rdat = lsr_dflt;
        end else rdat = rbr_val;
        wb_ack_i = 1'b1;
        wb_dat_i = wb_we_o ? 8'hEE : rdat;
        log_x.push_back({wb_we_o, wb_adr_o, rdat});
        log_c.push_back(cyc_cnt);
      end
      if (rx_valid_o) begin
        rx_log.push_back(rx_byte_o);
        if (rxv_prev) proto_err++;
      end
      if (init_done_o && !init_prev) init_cyc = cyc_cnt;
      if (err_o && !err_prev) err_cyc = cyc_cnt;
      ack_prev  = wb_ack_i;
      stb_prev  = wb_stb_o;
      req_prev  = {wb_we_o, wb_adr_o, wb_dat_o};
      rxv_prev  = rx_valid_o;
      init_prev = init_done_o;
      err_prev  = err_o;
    end
  end

  function automatic logic [11:0] xf(input bit we, input logic [2:0] a, input logic [7:0] d);
    return {we, a, d};
  endfunction

  function automatic logic [11:0] get_x(input int i);
    if (i >= 0 && i < log_x.size()) return log_x[i];
    return 12'hFFF;
  endfunction

  function automatic int find_lsr(input int start, input logic [7:0] v);
    for (int i = start; i < log_x.size(); i++)
      if (log_x[i] == {1'b0, 3'd5, v}) return i;
    return -1;
  endfunction

  task automatic clear_logs();
    log_x.delete();
    log_c.delete();
    rise_c.delete();
    rx_log.delete();
    lsr_q.delete();
    xfer_cnt = 0;
    init_cyc = -1;
    err_cyc  = -1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge wb_clk_i);
    #2;
  endtask

  task automatic wait_init(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (init_done_o) break;
    end
    tick(2);
  endtask

  logic [11:0] exp_init[6];
  logic [11:0] exp_echo[7];
  int k;
  int bad;
  int nx;
  int busy0;
  bit found;

  initial begin
    exp_init[0] = xf(1, 3'd3, 8'h83);
    exp_init[1] = xf(1, 3'd0, 8'h1B);
    exp_init[2] = xf(1, 3'd1, 8'h00);
    exp_init[3] = xf(1, 3'd3, 8'h03);
    exp_init[4] = xf(1, 3'd2, 8'hC7);
    exp_init[5] = xf(1, 3'd1, 8'h00);
    exp_echo[0] = xf(0, 3'd0, 8'h5A);
    exp_echo[1] = xf(0, 3'd5, 8'h01);
    exp_echo[2] = xf(0, 3'd5, 8'h01);
    exp_echo[3] = xf(0, 3'd5, 8'h01);
    exp_echo[4] = xf(0, 3'd5, 8'h21);
    exp_echo[5] = xf(1, 3'd0, 8'h5A);
    exp_echo[6] = xf(0, 3'd5, 8'h60);

    wb_rst_i  = 1'b1;
    echo_en_i = 1'b0;
    tick(3);
    check_val("rst_bus", {wb_cyc_o, wb_stb_o, wb_we_o}, 0);
    check_val("rst_sel", wb_sel_o, 4'b0001);
    check_val("rst_flags", {init_done_o, rx_valid_o, err_o}, 0);
    check_val("rst_data", {wb_adr_o, wb_dat_o, rx_byte_o}, 0);

    // 1: configuration sequence
    clear_logs();
    wb_rst_i = 1'b0;
    wait_init(100);
    for (int i = 0; i < 6; i++) check_val($sformatf("t1_wr%0d", i), get_x(i), exp_init[i]);
    check_val("t1_done_lat", (log_c.size() >= 6) ? init_cyc - log_c[5] : -1, 1);
    check_val("t1_proto", proto_err, 0);

    // 2: idle receiver, only LSR polls
    tick(60);
    bad = 0;
    for (int i = 6; i < log_x.size(); i++) if (log_x[i] != xf(0, 3'd5, 8'h60)) bad++;
    check_val("t2_only_lsr", bad, 0);
    check_val("t2_poll_cnt", (log_x.size() >= 16) ? 1 : 0, 1);
    check_val("t2_no_rxv", rx_log.size(), 0);

    // 3: echo path
    nx = log_x.size();
    echo_en_i = 1'b1;
    rbr_val = 8'h5A;
    lsr_q.push_back(8'h61);
    lsr_q.push_back(8'h01);
    lsr_q.push_back(8'h01);
    lsr_q.push_back(8'h01);
    lsr_q.push_back(8'h21);
    tick(60);
    k = find_lsr(nx, 8'h61);
    check_val("t3_found", (k >= 0) ? 1 : 0, 1);
    for (int j = 0; j < 7; j++) check_val($sformatf("t3_seq%0d", j), get_x(k + 1 + j), exp_echo[j]);
    check_val("t3_rx_cnt", rx_log.size(), 1);
    check_val("t3_rx_byte", (rx_log.size() > 0) ? rx_log[0] : 8'h00, 8'h5A);

    // 4: no echo
    nx = log_x.size();
    echo_en_i = 1'b0;
    rbr_val = 8'hA5;
    lsr_q.push_back(8'h61);
    tick(40);
    k = find_lsr(nx, 8'h61);
    check_val("t4_rbr", (k >= 0) ? get_x(k + 1) : 12'hFFF, xf(0, 3'd0, 8'hA5));
    check_val("t4_next_lsr", (k >= 0) ? get_x(k + 2) : 12'hFFF, xf(0, 3'd5, 8'h60));
    bad = 0;
    for (int i = nx; i < log_x.size(); i++) if (log_x[i][11]) bad++;
    check_val("t4_no_write", bad, 0);
    check_val("t4_rx_cnt", rx_log.size(), 2);
    check_val("t4_rx_byte", (rx_log.size() > 1) ? rx_log[1] : 8'h00, 8'hA5);
    check_val("t4_proto", proto_err, 0);

    // 6: reset in the middle of an RBR read
    hold_rbr = 1'b1;
    lsr_q.push_back(8'h61);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (wb_stb_o && !wb_we_o && wb_adr_o == 3'd0) begin
        found = 1'b1;
        break;
      end
    end
    check_val("t6_rbr_seen", found, 1);
    wb_rst_i = 1'b1;
    tick(1);
    check_val("t6_bus_drop", {wb_cyc_o, wb_stb_o}, 0);
    clear_logs();
    wb_rst_i = 1'b0;
    hold_rbr = 1'b0;
    wait_init(100);
    check_val("t6_restart", get_x(0), xf(1, 3'd3, 8'h83));
    check_val("t6_done", init_done_o, 1);
    check_val("t6_no_rxv", rx_log.size(), 0);

    // 5: ack withheld on the second configuration write
    wb_rst_i = 1'b1;
    hold_idx = 1;
    tick(2);
    clear_logs();
    wb_rst_i = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick(1);
      if (err_o) break;
    end
    tick(2);
    check_val("t5_err", err_o, 1);
    check_val("t5_err_lat", (rise_c.size() >= 2) ? err_cyc - rise_c[1] : -1, 255);
    check_val("t5_bus_drop", {wb_cyc_o, wb_stb_o}, 0);
    busy0 = busy_cnt;
    nx = log_x.size();
    tick(1000);
    check_val("t5_idle", busy_cnt - busy0, 0);
    check_val("t5_no_xfer", log_x.size() - nx, 0);
    check_val("t5_acked", log_x.size(), 1);
    check_val("t5_no_init", init_done_o, 0);
    check_val("t5_err_sticky", err_o, 1);
    check_val("t5_proto", proto_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
